sd_cmd_receiver: RTL and testbench
==================================

SD_CMD_RECEIVER -- requirements
Module: sd_cmd_receiver

Interface
REQ-001 CLK  input  1  system clock; all logic on rising edge.
REQ-002 RST  input  1  asynchronous, active-high reset.
REQ-003 SD_CLK  input  1  divided SD clock, generated in the CLK domain; no synchronizer required.
REQ-004 CMD_IN  input  1  SD CMD line from card, already registered in the CLK domain.
REQ-005 ARM  input  1  one-cycle pulse; start listening for a 48-bit response.
REQ-006 ABORT  input  1  one-cycle pulse; cancel reception.
REQ-007 TIMEOUT  input  8  SD_CLK rising edges to wait for start bit; 0 = wait forever.
REQ-008 BUSY  output  1  high from ARM acceptance until DONE or ABORT.
REQ-009 DONE  output  1  one-cycle completion pulse.
REQ-010 RSP_INDEX  output  6  received command index.
REQ-011 RSP_ARG  output  32  received argument/status field.
REQ-012 CRC_ERR  output  1  received CRC7 differs from computed CRC7.
REQ-013 FRAME_ERR  output  1  direction bit = 1 or end bit = 0.
REQ-014 TIMEOUT_ERR  output  1  no start bit within TIMEOUT edges.

Function
REQ-015 SHALL derive sample strobe = SD_CLK & ~SD_CLK_q (SD_CLK_q registered); CMD_IN sampled only on strobe cycles.
REQ-016 SHALL implement states IDLE, WAIT_START, SHIFT, FINISH.
REQ-017 IDLE: ARM -> WAIT_START; clear error flags, timeout counter, bit counter, CRC; BUSY=1 next cycle.
REQ-018 WAIT_START: strobe with CMD_IN=0 -> SHIFT, bit counter = 46 (start bit included in CRC).
REQ-019 WAIT_START: strobe with CMD_IN=1 increments 8-bit timeout counter; when incremented value equals TIMEOUT (TIMEOUT!=0) -> FINISH with TIMEOUT_ERR=1.
REQ-020 Start bit and timeout on same strobe impossible; CMD_IN=0 takes priority.
REQ-021 SHIFT: each strobe shifts CMD_IN into 47-bit register MSB-first, decrements bit counter; counter 0 strobe (end bit) -> FINISH.
REQ-022 CRC7 (x^7+x^3+1, init 0) SHALL cover start, direction, index, argument (40 bits); bits 7..1 compared with CRC7; bit 0 is end bit.
REQ-023 FINISH: lasts one cycle; DONE=1; RSP_INDEX, RSP_ARG, CRC_ERR, FRAME_ERR, TIMEOUT_ERR valid from DONE onward; -> IDLE, BUSY=0.
REQ-024 DONE SHALL occur exactly 2 CLK cycles after the strobe cycle sampling the end bit or reaching timeout.
REQ-025 On timeout, RSP_INDEX/RSP_ARG SHALL be 0; CRC_ERR=FRAME_ERR=0.
REQ-026 Result outputs SHALL hold until next accepted ARM.
REQ-027 ARM while BUSY SHALL be ignored.
REQ-028 ABORT in any non-IDLE state -> IDLE next cycle, BUSY=0, no DONE; ABORT with ARM same cycle: ABORT wins, ARM ignored.
REQ-029 SD_CLK static (no edges) SHALL stall receiver without error.

Reset
REQ-030 RST SHALL force state IDLE, BUSY=0, DONE=0, RSP_INDEX=0, RSP_ARG=0, all error flags 0, counters and CRC 0, SD_CLK_q=0.
REQ-031 RST mid-reception SHALL discard the frame; no DONE after release.

Structure
REQ-032 Shared package sd_cmd_pkg SHALL hold state encoding, response length 48, CRC7 polynomial 7'h09, field widths.
REQ-033 Serial CRC7 SHALL be a sub-module sd_crc7 (inputs: clk, rst, clear, enable, bit; output crc[6:0]).
REQ-034 Total RTL 120-400 lines.

Verification
REQ-035 R7 response bytes 08 00 00 01 AA 13, DIVIDER such that SD_CLK = CLK/4 -> DONE, RSP_INDEX=8, RSP_ARG=0x000001AA, all errors 0.
REQ-036 Same frame with last CRC byte 0x15 -> CRC_ERR=1, FRAME_ERR=0, RSP_ARG=0x000001AA.
REQ-037 CMD_IN held 1, TIMEOUT=5 -> DONE on 5th strobe +2 cycles, TIMEOUT_ERR=1, RSP fields 0.
REQ-038 ABORT at bit 20 of SHIFT, then ARM and valid frame -> no DONE for first, second decodes correctly.
REQ-039 ARM pulsed while BUSY and RST asserted mid-frame -> ARM ignored; after RST all outputs 0, no DONE.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-line response receiver:
// FSM encoding, frame geometry, CRC7 polynomial and field widths.
package sd_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_SHIFT      = 2'd2,
        ST_FINISH     = 2'd3
    } state_t;

    localparam int RSP_LEN   = 48;
    localparam int SHIFT_LEN = RSP_LEN - 1;
    localparam int INDEX_W   = 6;
    localparam int ARG_W     = 32;
    localparam int CRC_W     = 7;
    localparam int TMO_W     = 8;
    localparam int BIT_CNT_W = 6;

    localparam logic [CRC_W-1:0] CRC_POLY = 7'h09;

    // Bit counter value when the first bit after the start bit arrives,
    // and the value of the last bit that still feeds the CRC.
    localparam logic [BIT_CNT_W-1:0] FIRST_BIT_CNT    = BIT_CNT_W'(SHIFT_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_CRC_BIT_CNT = BIT_CNT_W'(CRC_W + 1);

    // Layout of the shift register once every bit after the start bit is in.
    typedef struct packed {
        logic               dir_bit;
        logic [INDEX_W-1:0] index;
        logic [ARG_W-1:0]   arg;
        logic [CRC_W-1:0]   crc;
        logic               end_bit;
    } rsp_frame_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[CRC_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{feedback}} & CRC_POLY);
        end
    end

endmodule

// File: rtl/sd_cmd_receiver.sv
// Receives a 48-bit SD response on CMD, sampled on rising SD_CLK edges
// seen in the CLK domain; reports index, argument and error flags.
//
// state         | meaning
// ST_IDLE       | not listening; results from last frame held
// ST_WAIT_START | counting SD_CLK edges until a start bit (CMD_IN=0)
// ST_SHIFT      | shifting in direction..end bit, MSB first
// ST_FINISH     | one cycle: publish results, pulse DONE
module sd_cmd_receiver
    import sd_cmd_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               SD_CLK,
    input  logic               CMD_IN,
    input  logic               ARM,
    input  logic               ABORT,
    input  logic [TMO_W-1:0]   TIMEOUT,
    output logic               BUSY,
    output logic               DONE,
    output logic [INDEX_W-1:0] RSP_INDEX,
    output logic [ARG_W-1:0]   RSP_ARG,
    output logic               CRC_ERR,
    output logic               FRAME_ERR,
    output logic               TIMEOUT_ERR
);

    state_t                 state;
    logic                   sd_clk_q;
    logic                   strobe;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [TMO_W-1:0]       tmo_next;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [SHIFT_LEN-1:0]   shift_q;
    rsp_frame_t             frame;
    logic                   timed_out;
    logic                   arm_accept;
    logic                   crc_enable;
    logic [CRC_W-1:0]       crc;

    assign strobe     = SD_CLK & ~sd_clk_q;
    assign tmo_next   = tmo_cnt + TMO_W'(1);
    assign frame      = rsp_frame_t'(shift_q);
    assign arm_accept = (state == ST_IDLE) && ARM && !ABORT;

    // Start bit plus every shifted bit down to the last argument bit.
    assign crc_enable = strobe &&
                        (((state == ST_WAIT_START) && !CMD_IN) ||
                         ((state == ST_SHIFT) && (bit_cnt >= LAST_CRC_BIT_CNT)));

    sd_crc7 u_crc7 (
        .clk    (CLK),
        .rst    (RST),
        .clear  (arm_accept),
        .enable (crc_enable),
        .bit_in (CMD_IN),
        .crc    (crc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            sd_clk_q    <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RSP_INDEX   <= '0;
            RSP_ARG     <= '0;
            CRC_ERR     <= 1'b0;
            FRAME_ERR   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            tmo_cnt     <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            timed_out   <= 1'b0;
        end else begin
            sd_clk_q <= SD_CLK;
            DONE     <= 1'b0;
            if (ABORT && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm_accept) begin
                            state       <= ST_WAIT_START;
                            BUSY        <= 1'b1;
                            RSP_INDEX   <= '0;
                            RSP_ARG     <= '0;
                            CRC_ERR     <= 1'b0;
                            FRAME_ERR   <= 1'b0;
                            TIMEOUT_ERR <= 1'b0;
                            tmo_cnt     <= '0;
                            bit_cnt     <= '0;
                            shift_q     <= '0;
                            timed_out   <= 1'b0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (strobe) begin
                            if (!CMD_IN) begin
                                state   <= ST_SHIFT;
                                bit_cnt <= FIRST_BIT_CNT;
                            end else begin
                                tmo_cnt <= tmo_next;
                                if ((TIMEOUT != '0) && (tmo_next == TIMEOUT)) begin
                                    state     <= ST_FINISH;
                                    timed_out <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (strobe) begin
                            shift_q <= {shift_q[SHIFT_LEN-2:0], CMD_IN};
                            if (bit_cnt == '0) begin
                                state <= ST_FINISH;
                            end else begin
                                bit_cnt <= bit_cnt - BIT_CNT_W'(1);
                            end
                        end
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        if (timed_out) begin
                            TIMEOUT_ERR <= 1'b1;
                            RSP_INDEX   <= '0;
                            RSP_ARG     <= '0;
                            CRC_ERR     <= 1'b0;
                            FRAME_ERR   <= 1'b0;
                        end else begin
                            RSP_INDEX <= frame.index;
                            RSP_ARG   <= frame.arg;
                            CRC_ERR   <= (crc != frame.crc);
                            FRAME_ERR <= frame.dir_bit | ~frame.end_bit;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_receiver.sv
// Bench for sd_cmd_receiver: frame-level reference model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_sd_cmd_receiver;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SD_CLK = 1'b0;
    logic        CMD_IN = 1'b1;
    logic        ARM = 1'b0;
    logic        ABORT = 1'b0;
    logic [7:0]  TIMEOUT = 8'd0;
    logic        BUSY;
    logic        DONE;
    logic [5:0]  RSP_INDEX;
    logic [31:0] RSP_ARG;
    logic        CRC_ERR;
    logic        FRAME_ERR;
    logic        TIMEOUT_ERR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;

    logic       sd_run = 1'b1;
    logic       sd_fell = 1'b0;
    logic       sd_old = 1'b0;
    logic [1:0] div = 2'd0;
    logic       sd_q_obs = 1'b0;

    localparam logic [47:0] R7_OK  = 48'h08_0000_01AA_13;
    localparam logic [47:0] R7_BAD = 48'h08_0000_01AA_15;
    localparam logic [47:0] R7_END0 = 48'h08_0000_01AA_12;

    sd_cmd_receiver dut (
        .CLK         (CLK),
        .RST         (RST),
        .SD_CLK      (SD_CLK),
        .CMD_IN      (CMD_IN),
        .ARM         (ARM),
        .ABORT       (ABORT),
        .TIMEOUT     (TIMEOUT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .RSP_INDEX   (RSP_INDEX),
        .RSP_ARG     (RSP_ARG),
        .CRC_ERR     (CRC_ERR),
        .FRAME_ERR   (FRAME_ERR),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial forever #5 CLK = ~CLK;

    // SD_CLK = CLK/4, updated just after each CLK edge; can be frozen.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sd_run) begin
                sd_old  = SD_CLK;
                div     = div + 2'd1;
                SD_CLK  = div[1];
                sd_fell = sd_old & ~SD_CLK;
            end else begin
                sd_fell = 1'b0;
            end
        end
    end

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        sd_q_obs <= SD_CLK;
        if (DONE) done_count <= done_count + 1;
    end

    // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1 (0x89).
    function automatic logic [6:0] crc7_div(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    // Reference model: tracks bits seen on SD_CLK rising edges as a frame.
    logic        m_sdq, m_busy, m_pend, m_to, m_done;
    int          m_nbits;
    logic [7:0]  m_tcnt;
    logic [47:0] m_frame;
    logic [5:0]  m_idx;
    logic [31:0] m_arg;
    logic        m_crc_err, m_frame_err, m_to_err;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_sdq <= 0; m_busy <= 0; m_pend <= 0; m_to <= 0; m_done <= 0;
            m_nbits <= 0; m_tcnt <= 0; m_frame <= 0;
            m_idx <= 0; m_arg <= 0; m_crc_err <= 0; m_frame_err <= 0; m_to_err <= 0;
        end else begin
            m_sdq  <= SD_CLK;
            m_done <= 1'b0;
            if (m_busy && ABORT) begin
                m_busy <= 1'b0;
                m_pend <= 1'b0;
            end else if (!m_busy) begin
                if (ARM && !ABORT) begin
                    m_busy <= 1'b1; m_pend <= 0; m_to <= 0; m_nbits <= 0;
                    m_tcnt <= 0; m_frame <= 0;
                    m_idx <= 0; m_arg <= 0; m_crc_err <= 0; m_frame_err <= 0; m_to_err <= 0;
                end
            end else if (m_pend) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
                m_pend <= 1'b0;
                if (m_to) begin
                    m_to_err <= 1'b1; m_idx <= 0; m_arg <= 0;
                    m_crc_err <= 1'b0; m_frame_err <= 1'b0;
                end else begin
                    m_idx       <= m_frame[45:40];
                    m_arg       <= m_frame[39:8];
                    m_crc_err   <= (crc7_div(m_frame[47:8]) != m_frame[7:1]);
                    m_frame_err <= m_frame[46] | ~m_frame[0];
                end
            end else if (SD_CLK && !m_sdq) begin
                if (m_nbits == 0) begin
                    if (!CMD_IN) begin
                        m_frame <= 48'h0;
                        m_nbits <= 1;
                    end else begin
                        m_tcnt <= m_tcnt + 8'd1;
                        if ((TIMEOUT != 8'd0) && (8'(m_tcnt + 8'd1) == TIMEOUT)) begin
                            m_pend <= 1'b1;
                            m_to   <= 1'b1;
                        end
                    end
                end else begin
                    m_frame <= {m_frame[46:0], CMD_IN};
                    m_nbits <= m_nbits + 1;
                    if (m_nbits == 47) m_pend <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            chk("busy", BUSY, m_busy);
            chk("done", DONE, m_done);
            if (!m_busy) begin
                chk("rsp_index", RSP_INDEX, m_idx);
                chk("rsp_arg", RSP_ARG, m_arg);
                chk("crc_err", CRC_ERR, m_crc_err);
                chk("frame_err", FRAME_ERR, m_frame_err);
                chk("timeout_err", TIMEOUT_ERR, m_to_err);
            end
        end
    end

    task automatic wait_fall();
        bit ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge CLK);
            #2;
            if (sd_fell) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sd_fall_wait: no SD_CLK fall within 64 cycles");
        end
    endtask

    task automatic send_bits(input logic [47:0] f, input int n);
        wait_fall();
        for (int i = 0; i < n; i++) begin
            CMD_IN = f[47-i];
            wait_fall();
        end
        CMD_IN = 1'b1;
    endtask

    task automatic pulse_arm();
        @(posedge CLK); #1 ARM = 1'b1;
        @(posedge CLK); #1 ARM = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge CLK); #1 ABORT = 1'b1;
        @(posedge CLK); #1 ABORT = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        for (int i = 0; i < 30 && done_count <= d0; i++) @(negedge CLK);
        chk(nm, done_count, d0 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n, t5, td;
        logic [47:0] f_dir;

        chk("model_crc_r7", crc7_div(40'h08_0000_01AA), 7'h09);
        chk("model_crc_cmd8", crc7_div(40'h48_0000_01AA), 7'h43);

        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_index", RSP_INDEX, 0);
        chk("rst_arg", RSP_ARG, 0);
        chk("rst_errs", {CRC_ERR, FRAME_ERR, TIMEOUT_ERR}, 0);

        // Valid R7 response.
        d0 = done_count;
        pulse_arm();
        @(negedge CLK);
        chk("arm_busy", BUSY, 1);
        send_bits(R7_OK, 48);
        wait_done("r7_done", d0);
        @(negedge CLK);
        chk("r7_index", RSP_INDEX, 6'd8);
        chk("r7_arg", RSP_ARG, 32'h0000_01AA);
        chk("r7_errs", {CRC_ERR, FRAME_ERR, TIMEOUT_ERR}, 3'b000);
        chk("r7_busy_after", BUSY, 0);

        // Corrupted CRC byte.
        d0 = done_count;
        pulse_arm();
        send_bits(R7_BAD, 48);
        wait_done("crc_done", d0);
        @(negedge CLK);
        chk("crc_crc_err", CRC_ERR, 1);
        chk("crc_frame_err", FRAME_ERR, 0);
        chk("crc_arg", RSP_ARG, 32'h0000_01AA);

        // Direction bit set, CRC correct.
        f_dir = {8'h48, 32'h0000_01AA, crc7_div(40'h48_0000_01AA), 1'b1};
        d0 = done_count;
        pulse_arm();
        send_bits(f_dir, 48);
        wait_done("dir_done", d0);
        @(negedge CLK);
        chk("dir_frame_err", FRAME_ERR, 1);
        chk("dir_crc_err", CRC_ERR, 0);
        chk("dir_index", RSP_INDEX, 6'd8);

        // End bit 0.
        d0 = done_count;
        pulse_arm();
        send_bits(R7_END0, 48);
        wait_done("end_done", d0);
        @(negedge CLK);
        chk("end_frame_err", FRAME_ERR, 1);
        chk("end_crc_err", CRC_ERR, 0);

        // Timeout after 5 SD_CLK rising edges, DONE two cycles later.
        TIMEOUT = 8'd5;
        CMD_IN  = 1'b1;
        pulse_arm();
        n = 0;
        t5 = -1;
        for (int i = 0; i < 200 && t5 < 0; i++) begin
            @(negedge CLK);
            if (SD_CLK && !sd_q_obs) begin
                n++;
                if (n == 5) t5 = cyc;
            end
        end
        td = -100;
        for (int i = 0; i < 10 && td < 0; i++) begin
            @(negedge CLK);
            if (DONE) td = cyc;
        end
        chk("tmo_latency", td - t5, 2);
        @(negedge CLK);
        chk("tmo_flag", TIMEOUT_ERR, 1);
        chk("tmo_fields", {RSP_INDEX, RSP_ARG, CRC_ERR, FRAME_ERR}, 0);
        TIMEOUT = 8'd0;

        // Abort partway through SHIFT, then a clean frame.
        d0 = done_count;
        pulse_arm();
        send_bits(R7_OK, 21);
        pulse_abort();
        repeat (30) @(negedge CLK);
        chk("abort_no_done", done_count, d0);
        chk("abort_busy", BUSY, 0);
        pulse_arm();
        send_bits(R7_OK, 48);
        wait_done("post_abort_done", d0);
        @(negedge CLK);
        chk("post_abort_index", RSP_INDEX, 6'd8);
        chk("post_abort_arg", RSP_ARG, 32'h0000_01AA);
        chk("post_abort_errs", {CRC_ERR, FRAME_ERR, TIMEOUT_ERR}, 0);

        // ABORT and ARM together while idle: ARM is dropped.
        @(posedge CLK); #1 ARM = 1'b1; ABORT = 1'b1;
        @(posedge CLK); #1 ARM = 1'b0; ABORT = 1'b0;
        @(negedge CLK);
        chk("abort_arm_busy", BUSY, 0);

        // Static SD_CLK stalls the receiver; resuming lets it time out.
        TIMEOUT = 8'd2;
        sd_run  = 1'b0;
        d0 = done_count;
        pulse_arm();
        repeat (40) @(negedge CLK);
        chk("stall_busy", BUSY, 1);
        chk("stall_no_done", done_count, d0);
        sd_run = 1'b1;
        wait_done("stall_resume_done", d0);
        @(negedge CLK);
        chk("stall_tmo_flag", TIMEOUT_ERR, 1);
        TIMEOUT = 8'd0;

        // ARM while busy ignored, then reset mid-frame discards it.
        pulse_arm();
        send_bits(R7_OK, 20);
        pulse_arm();
        send_bits(R7_OK, 10);
        d0 = done_count;
        @(posedge CLK); #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        repeat (60) @(negedge CLK);
        chk("rst_mid_no_done", done_count, d0);
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_index", RSP_INDEX, 0);
        chk("rst_mid_arg", RSP_ARG, 0);
        chk("rst_mid_errs", {CRC_ERR, FRAME_ERR, TIMEOUT_ERR}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
